// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 7->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the closest hit to ptr is kept last.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with hold-time limit, break-before-make release
// and a one-cycle timeout pulse for forced revokes.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic             timeout_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             hold_limit;
  logic             normal_release;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // A normal release (done or request dropped) takes precedence over the hold limit,
  // so timeout only fires when the limit is the sole cause.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = grant_idx;
    ptr_nxt        = ptr;
    hold_nxt       = hold_cnt;
    timeout_nxt    = 1'b0;
    hold_limit     = (hold_cnt == HOLD_LAST);
    normal_release = done || !req[grant_idx];

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          idx_nxt   = pick_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (normal_release || hold_limit) begin
          state_nxt   = IDLE;
          ptr_nxt     = grant_idx + IDX_W'(1);
          timeout_nxt = hold_limit && !normal_release;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Derived straight from the state register so an async reset drops it at once.
  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (instantiated with MAX_HOLD=4).
module tb_rr_arbiter_8;
  import arb_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;
  logic [7:0]         dec_out;

  int total;
  int bad;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  // Model of the downstream 3-to-8 decoder driven by grant_idx/grant_valid.
  assign dec_out = grant_valid ? (8'b1 << grant_idx) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;

    doReset();
    checkOutput("rst_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_idx", 32'(grant_idx), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);

    // Single requester 2, then release; ptr=3 shown by picking 3 over 0 and 2.
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("r2_valid", 32'(grant_valid), 32'd1);
    checkOutput("r2_idx", 32'(grant_idx), 32'd2);
    applyStimulus(8'b0000_0100, 1'b1);
    checkOutput("r2_rel_valid", 32'(grant_valid), 32'd0);
    checkOutput("r2_rel_timeout", 32'(timeout), 32'd0);
    applyStimulus(8'b0000_1101, 1'b0);
    checkOutput("ptr3_idx", 32'(grant_idx), 32'd3);
    checkOutput("ptr3_valid", 32'(grant_valid), 32'd1);
    applyStimulus(8'b0000_1101, 1'b1);
    checkOutput("ptr3_rel", 32'(grant_valid), 32'd0);

    // Full rotation with all requesting, done every grant.
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("rot%0d_valid", k), 32'(grant_valid), 32'd1);
      checkOutput($sformatf("rot%0d_idx", k), 32'(grant_idx), 32'(k % 8));
      applyStimulus(8'hFF, 1'b1);
      checkOutput($sformatf("rot%0d_gap", k), 32'(grant_valid), 32'd0);
    end

    // Wrap from 7 to 0 then 1.
    doReset();
    applyStimulus(8'b1000_0000, 1'b0);
    checkOutput("w7_idx", 32'(grant_idx), 32'd7);
    applyStimulus(8'b1000_0011, 1'b1);
    checkOutput("w7_rel", 32'(grant_valid), 32'd0);
    applyStimulus(8'b1000_0011, 1'b0);
    checkOutput("w0_idx", 32'(grant_idx), 32'd0);
    checkOutput("w0_valid", 32'(grant_valid), 32'd1);
    applyStimulus(8'b1000_0011, 1'b1);
    applyStimulus(8'b1000_0011, 1'b0);
    checkOutput("w1_idx", 32'(grant_idx), 32'd1);

    // Hold limit: four GRANT cycles, one IDLE with timeout, regrant.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'b0000_0001, 1'b0);
      checkOutput($sformatf("hold%0d_valid", k), 32'(grant_valid), 32'd1);
      checkOutput($sformatf("hold%0d_to", k), 32'(timeout), 32'd0);
    end
    applyStimulus(8'b0000_0001, 1'b0);
    checkOutput("to_valid", 32'(grant_valid), 32'd0);
    checkOutput("to_pulse", 32'(timeout), 32'd1);
    applyStimulus(8'b0000_0001, 1'b0);
    checkOutput("regrant_valid", 32'(grant_valid), 32'd1);
    checkOutput("regrant_idx", 32'(grant_idx), 32'd0);
    checkOutput("regrant_to", 32'(timeout), 32'd0);

    // done coincident with the last hold cycle: normal release.
    for (int k = 0; k < 3; k++) applyStimulus(8'b0000_0001, 1'b0);
    checkOutput("coinc_pre", 32'(grant_valid), 32'd1);
    applyStimulus(8'b0000_0001, 1'b1);
    checkOutput("coinc_valid", 32'(grant_valid), 32'd0);
    checkOutput("coinc_to", 32'(timeout), 32'd0);

    // Request drop coincident with the last hold cycle: normal release.
    applyStimulus(8'b0000_0001, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(8'b0000_0001, 1'b0);
    applyStimulus(8'b0000_0000, 1'b0);
    checkOutput("drop_valid", 32'(grant_valid), 32'd0);
    checkOutput("drop_to", 32'(timeout), 32'd0);

    // done ignored in IDLE; idx held while idle with no requests.
    applyStimulus(8'b0000_0000, 1'b1);
    checkOutput("idle_done_valid", 32'(grant_valid), 32'd0);
    applyStimulus(8'b0000_0010, 1'b1);
    checkOutput("idle_done_grant", 32'(grant_valid), 32'd1);
    checkOutput("idle_done_idx", 32'(grant_idx), 32'd1);
    applyStimulus(8'b0000_0010, 1'b1);
    applyStimulus(8'b0000_0000, 1'b0);
    checkOutput("idle_hold_idx", 32'(grant_idx), 32'd1);
    checkOutput("idle_hold_valid", 32'(grant_valid), 32'd0);

    // Async reset mid-grant, between edges.
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("pre_arst_dec", 32'(dec_out), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(grant_valid), 32'd0);
    checkOutput("arst_dec", 32'(dec_out), 32'h00);
    checkOutput("arst_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'b0000_1001, 1'b0);
    checkOutput("post_arst_idx", 32'(grant_idx), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
